// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA constants and the W-stage instruction class used by the
// register file / writeback decode slice.
//   - opcode and funct encodings for the supported instruction subset
//   - architectural register aliases (REG_ZERO, REG_RA)
//   - instr_cls_e: coarse class of an instruction, drives destination decode
package isa_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_CAL_R,
        CLS_CAL_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JR,
        CLS_J,
        CLS_JAL
    } instr_cls_e;

endpackage

// File: rtl/hctrl.sv
// hctrl: instruction classifier. Decodes one instruction word into its class
// and extracts the register fields.
//   instr  in   32  instruction word
//   cls    out  4   instruction class (CLS_NONE for anything unrecognised)
//   rs     out  5   instr[25:21]
//   rt     out  5   instr[20:16]
//   rd     out  5   instr[15:11]
module hctrl
    import isa_pkg::*;
(
    input  logic [31:0] instr,
    output instr_cls_e  cls,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign unused_shamt = instr[10:6];

    // Unknown or X opcodes fall to the defaults, so they never yield a
    // destination. A bubble (all zeros = sll) is SPECIAL with funct 0 and
    // lands in CLS_NONE as well.
    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU, FN_SUBU: cls = CLS_CAL_R;
                    FN_JR:            cls = CLS_JR;
                    default:          cls = CLS_NONE;
                endcase
            end
            OP_ORI, OP_LUI, OP_ADDIU: cls = CLS_CAL_I;
            OP_LW:                    cls = CLS_LOAD;
            OP_SW:                    cls = CLS_STORE;
            OP_BEQ:                   cls = CLS_BRANCH;
            OP_J:                     cls = CLS_J;
            OP_JAL:                   cls = CLS_JAL;
            default:                  cls = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/grf_wb.sv
// grf_wb: general register file with W-stage writeback decode.
// 31 writable GPRs ($0 hardwired to zero), two combinational read ports for
// the D stage with write-through from the W stage, one write port.
//   clk         in   1      pipeline clock, writes on rising edge
//   reset_n     in   1      asynchronous active-low reset
//   instrW      in   32     W-stage instruction (32'h0 = bubble)
//   wdataW      in   DW     W-stage result selected by the datapath
//   instrD      in   32     D-stage instruction, rs=[25:21], rt=[20:16]
//   rdata_rs    out  DW     GPR[rs_D] with write-through
//   rdata_rt    out  DW     GPR[rt_D] with write-through
//   wt_rs       out  1      rdata_rs was taken from wdataW
//   wt_rt       out  1      rdata_rt was taken from wdataW
//   wr_en       out  1      commit this cycle (destination != $0)
//   wr_addr     out  5      destination of this cycle's commit
//   commit_cnt  out  CNT_W  GPR writes since reset, wraps
module grf_wb
    import isa_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instrW,
    input  logic [DW-1:0]    wdataW,
    input  logic [31:0]      instrD,
    output logic [DW-1:0]    rdata_rs,
    output logic [DW-1:0]    rdata_rt,
    output logic             wt_rs,
    output logic             wt_rt,
    output logic             wr_en,
    output logic [4:0]       wr_addr,
    output logic [CNT_W-1:0] commit_cnt
);

    instr_cls_e  cls_w;
    logic [4:0]  rt_w;
    logic [4:0]  rd_w;
    logic [4:0]  unused_rs_w;
    logic [21:0] unused_instr_d;

    logic [4:0]  rs_d;
    logic [4:0]  rt_d;

    logic        has_dest;
    logic [4:0]  dest;

    logic [DW-1:0] gpr [1:NREG-1];

    hctrl u_hctrl_w (
        .instr (instrW),
        .cls   (cls_w),
        .rs    (unused_rs_w),
        .rt    (rt_w),
        .rd    (rd_w)
    );

    assign rs_d           = instrD[25:21];
    assign rt_d           = instrD[20:16];
    assign unused_instr_d = {instrD[31:26], instrD[15:0]};

    always_comb begin
        has_dest = 1'b0;
        dest     = REG_ZERO;
        case (cls_w)
            CLS_CAL_R: begin
                has_dest = 1'b1;
                dest     = rd_w;
            end
            CLS_CAL_I, CLS_LOAD: begin
                has_dest = 1'b1;
                dest     = rt_w;
            end
            CLS_JAL: begin
                has_dest = 1'b1;
                dest     = REG_RA;
            end
            default: begin
                has_dest = 1'b0;
                dest     = REG_ZERO;
            end
        endcase
    end

    assign wr_en   = has_dest && (dest != REG_ZERO);
    assign wr_addr = dest;

    // Async reset clears the array directly, so a write pending in the same
    // cycle as a reset pulse is lost and reads see zero immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else if (wr_en) begin
            gpr[wr_addr] <= wdataW;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_cnt <= '0;
        end else if (wr_en) begin
            commit_cnt <= commit_cnt + CNT_W'(1);
        end
    end

    // Write-through: D reads the value W commits this cycle. wr_en already
    // excludes $0, the explicit index check keeps the flag tied to the read.
    always_comb begin
        wt_rs = wr_en && (wr_addr == rs_d) && (rs_d != REG_ZERO);
        wt_rt = wr_en && (wr_addr == rt_d) && (rt_d != REG_ZERO);

        if (wt_rs) begin
            rdata_rs = wdataW;
        end else if (rs_d == REG_ZERO) begin
            rdata_rs = '0;
        end else begin
            rdata_rs = gpr[rs_d];
        end

        if (wt_rt) begin
            rdata_rt = wdataW;
        end else if (rt_d == REG_ZERO) begin
            rdata_rt = '0;
        end else begin
            rdata_rt = gpr[rt_d];
        end
    end

endmodule

// File: tb/tb_grf_wb.sv
module tb_grf_wb;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic        wt_rs;
        logic        wt_rt;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] cnt;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] iw;
        logic [31:0] wd;
        logic [31:0] id;
        obs_t        exp;
    } step_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] instrW;
    logic [31:0] wdataW;
    logic [31:0] instrD;
    logic [31:0] rdata_rs;
    logic [31:0] rdata_rt;
    logic        wt_rs;
    logic        wt_rt;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] commit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t  sb_exp  [$];
    string sb_name [$];

    grf_wb #(.NREG(32), .DW(32), .CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instrW     (instrW),
        .wdataW     (wdataW),
        .instrD     (instrD),
        .rdata_rs   (rdata_rs),
        .rdata_rt   (rdata_rt),
        .wt_rs      (wt_rs),
        .wt_rt      (wt_rt),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoded instructions used by the scenarios.
    localparam logic [31:0] I_BUBBLE   = 32'h0000_0000;
    localparam logic [31:0] I_ORI_8    = 32'h3408_1234; // ori  $8,$0,0x1234
    localparam logic [31:0] I_ORI_0    = 32'h3400_FFFF; // ori  $0,$0,0xffff
    localparam logic [31:0] I_ADDU_9   = 32'h0022_4821; // addu $9,$1,$2
    localparam logic [31:0] I_JAL      = 32'h0C00_0100; // jal  0x400
    localparam logic [31:0] I_LW_4     = 32'h8FA4_0000; // lw   $4,0($29)
    localparam logic [31:0] I_SW_4     = 32'hAFA4_0000; // sw   $4,0($29)
    localparam logic [31:0] I_BAD_OP   = 32'hFC08_0000; // opcode 0x3f
    localparam logic [31:0] I_BEQ      = 32'h1109_0004; // beq  $8,$9,4
    localparam logic [31:0] I_JR_31    = 32'h03E0_0008; // jr   $31
    localparam logic [31:0] I_J        = 32'h0800_0040; // j    0x100
    localparam logic [31:0] I_LUI_10   = 32'h3C0A_ABCD; // lui  $10,0xabcd
    localparam logic [31:0] I_SUBU_12  = 32'h0000_6023; // subu $12,$0,$0
    localparam logic [31:0] I_ADDIU_11 = 32'h240B_0001; // addiu $11,$0,1

    function automatic logic [31:0] mk_d(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, 16'h0000};
    endfunction

    function automatic obs_t mk_exp(input logic [31:0] rs, input logic [31:0] rt,
                                    input logic wts, input logic wtt, input logic we,
                                    input logic [4:0] wa, input logic [31:0] cnt);
        obs_t e;
        e.rs = rs; e.rt = rt; e.wt_rs = wts; e.wt_rt = wtt;
        e.we = we; e.wa = wa; e.cnt = cnt;
        return e;
    endfunction

    function automatic step_t mk_step(input string name, input logic [31:0] iw,
                                      input logic [31:0] wd, input logic [31:0] id,
                                      input obs_t exp);
        step_t s;
        s.name = name; s.iw = iw; s.wd = wd; s.id = id; s.exp = exp;
        return s;
    endfunction

    function automatic obs_t sample_dut();
        return {rdata_rs, rdata_rt, wt_rs, wt_rt, wr_en, wr_addr, commit_cnt};
    endfunction

    // Drives one step's inputs and queues its expectation.
    task automatic drive_step(input step_t s);
        instrW = s.iw;
        wdataW = s.wd;
        instrD = s.id;
        sb_exp.push_back(s.exp);
        sb_name.push_back(s.name);
    endtask

    task automatic test_reset();
        obs_t got, exp;
        string nm;
        drive_step(mk_step("reset_hold", I_BUBBLE, 32'h0, mk_d(5, 31),
                           mk_exp(0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        got = sample_dut(); exp = sb_exp.pop_front(); nm = sb_name.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive_step(mk_step($sformatf("reset_idle_%0d", i), I_BUBBLE, 32'h0,
                               mk_d(5, 31), mk_exp(0, 0, 0, 0, 0, 0, 0)));
            @(negedge clk);
            got = sample_dut(); exp = sb_exp.pop_front(); nm = sb_name.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", nm, got, exp);
            end
        end
    endtask

    task automatic test_cal_i_and_wt();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk_step("ori_commit", I_ORI_8, 32'h1234, mk_d(0, 0),
                             mk_exp(0, 0, 0, 0, 1, 8, 0)));
        st.push_back(mk_step("ori_readback", I_BUBBLE, 32'h0, mk_d(8, 0),
                             mk_exp(32'h1234, 0, 0, 0, 0, 0, 1)));
        st.push_back(mk_step("wt_same_cycle", I_ADDU_9, 32'hDEADBEEF, mk_d(9, 9),
                             mk_exp(32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 1, 9, 1)));
        st.push_back(mk_step("wt_readback", I_BUBBLE, 32'h0, mk_d(9, 8),
                             mk_exp(32'hDEADBEEF, 32'h1234, 0, 0, 0, 0, 2)));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive_step(st[i]);
            @(negedge clk);
            got = sample_dut(); exp = sb_exp.pop_front(); nm = sb_name.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", nm, got, exp);
            end
        end
    endtask

    task automatic test_zero_guard();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk_step("zero_dest", I_ORI_0, 32'hFFFF, mk_d(0, 8),
                             mk_exp(0, 32'h1234, 0, 0, 0, 0, 2)));
        st.push_back(mk_step("zero_after", I_BUBBLE, 32'h0, mk_d(0, 0),
                             mk_exp(0, 0, 0, 0, 0, 0, 2)));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive_step(st[i]);
            @(negedge clk);
            got = sample_dut(); exp = sb_exp.pop_front(); nm = sb_name.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", nm, got, exp);
            end
        end
    endtask

    task automatic test_jal_load_store();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk_step("jal_ra", I_JAL, 32'h3008, mk_d(31, 4),
                             mk_exp(32'h3008, 0, 1, 0, 1, 31, 2)));
        st.push_back(mk_step("lw_4", I_LW_4, 32'h55, mk_d(31, 4),
                             mk_exp(32'h3008, 32'h55, 0, 1, 1, 4, 3)));
        st.push_back(mk_step("sw_nowrite", I_SW_4, 32'h77, mk_d(4, 31),
                             mk_exp(32'h55, 32'h3008, 0, 0, 0, 0, 4)));
        st.push_back(mk_step("jls_after", I_BUBBLE, 32'h0, mk_d(4, 31),
                             mk_exp(32'h55, 32'h3008, 0, 0, 0, 0, 4)));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive_step(st[i]);
            @(negedge clk);
            got = sample_dut(); exp = sb_exp.pop_front(); nm = sb_name.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", nm, got, exp);
            end
        end
    endtask

    task automatic test_other_ops();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk_step("bad_opcode", I_BAD_OP, 32'hBAD, mk_d(8, 0),
                             mk_exp(32'h1234, 0, 0, 0, 0, 0, 4)));
        st.push_back(mk_step("beq_nowrite", I_BEQ, 32'hBAD, mk_d(9, 8),
                             mk_exp(32'hDEADBEEF, 32'h1234, 0, 0, 0, 0, 4)));
        st.push_back(mk_step("jr_nowrite", I_JR_31, 32'hBAD, mk_d(31, 31),
                             mk_exp(32'h3008, 32'h3008, 0, 0, 0, 0, 4)));
        st.push_back(mk_step("j_nowrite", I_J, 32'hBAD, mk_d(4, 4),
                             mk_exp(32'h55, 32'h55, 0, 0, 0, 0, 4)));
        st.push_back(mk_step("lui_10", I_LUI_10, 32'hABCD0000, mk_d(10, 10),
                             mk_exp(32'hABCD0000, 32'hABCD0000, 1, 1, 1, 10, 4)));
        st.push_back(mk_step("subu_12", I_SUBU_12, 32'hFFFFFFFF, mk_d(10, 12),
                             mk_exp(32'hABCD0000, 32'hFFFFFFFF, 0, 1, 1, 12, 5)));
        st.push_back(mk_step("addiu_11", I_ADDIU_11, 32'h1, mk_d(11, 12),
                             mk_exp(32'h1, 32'hFFFFFFFF, 1, 0, 1, 11, 6)));
        st.push_back(mk_step("ops_after", I_BUBBLE, 32'h0, mk_d(11, 10),
                             mk_exp(32'h1, 32'hABCD0000, 0, 0, 0, 0, 7)));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive_step(st[i]);
            @(negedge clk);
            got = sample_dut(); exp = sb_exp.pop_front(); nm = sb_name.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", nm, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk_step("b2b_first", I_ADDU_9, 32'h1111, mk_d(9, 9),
                             mk_exp(32'h1111, 32'h1111, 1, 1, 1, 9, 7)));
        st.push_back(mk_step("b2b_second", I_ADDU_9, 32'h2222, mk_d(9, 0),
                             mk_exp(32'h2222, 0, 1, 0, 1, 9, 8)));
        st.push_back(mk_step("b2b_after", I_BUBBLE, 32'h0, mk_d(9, 9),
                             mk_exp(32'h2222, 32'h2222, 0, 0, 0, 0, 9)));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive_step(st[i]);
            @(negedge clk);
            got = sample_dut(); exp = sb_exp.pop_front(); nm = sb_name.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", nm, got, exp);
            end
        end
    endtask

    // Reset is pulsed between clock edges, so every check here is taken a
    // couple of time units after the stimulus rather than on the negedge.
    task automatic test_async_reset();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk_step("ar_before", I_ADDU_9, 32'h3333, mk_d(8, 31),
                             mk_exp(32'h1234, 32'h3008, 0, 0, 1, 9, 9)));
        st.push_back(mk_step("ar_asserted", I_ADDU_9, 32'h3333, mk_d(8, 31),
                             mk_exp(0, 0, 0, 0, 1, 9, 0)));
        st.push_back(mk_step("ar_wt_in_reset", I_ADDU_9, 32'h3333, mk_d(9, 31),
                             mk_exp(32'h3333, 0, 1, 0, 1, 9, 0)));
        st.push_back(mk_step("ar_edge_in_reset", I_BUBBLE, 32'h0, mk_d(9, 31),
                             mk_exp(0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk_step("ar_first_write", I_ADDU_9, 32'h4444, mk_d(9, 8),
                             mk_exp(32'h4444, 0, 1, 0, 1, 9, 0)));
        st.push_back(mk_step("ar_readback", I_BUBBLE, 32'h0, mk_d(9, 8),
                             mk_exp(32'h4444, 0, 0, 0, 0, 0, 1)));
        foreach (st[i]) begin
            case (i)
                0: begin @(posedge clk); #1; end
                1: reset_n = 1'b0;
                2: ;
                3: begin @(posedge clk); #1; end
                4: begin reset_n = 1'b1; @(posedge clk); #1; end
                default: begin @(posedge clk); #1; end
            endcase
            drive_step(st[i]);
            #2;
            got = sample_dut(); exp = sb_exp.pop_front(); nm = sb_name.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", nm, got, exp);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        instrW  = 32'h0;
        wdataW  = 32'h0;
        instrD  = 32'h0;
        test_reset();
        test_cal_i_and_wt();
        test_zero_guard();
        test_jal_load_store();
        test_other_ops();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
